// File: rtl/fft_frame_loader_7_pkg.sv
// Shared constants and types for the FFT front end (loader, core and benches).
package fft_frame_loader_7_pkg;

    localparam int unsigned SAMPLE_W            = 12;
    localparam int unsigned FFT_N               = 8;
    localparam int unsigned FFT_LATENCY_DEFAULT = 3;
    localparam int unsigned FILL_W              = $clog2(FFT_N + 1);

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fft_frame_loader_7_valid_delay_line.sv
// Fixed-depth shift register for a 1-bit valid strobe; keeps pulse multiplicity.
module fft_frame_loader_7_valid_delay_line #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] tap_q;
    logic [DEPTH-1:0] tap_d;

    always_comb begin
        tap_d    = tap_q;
        tap_d[0] = in_valid;
        for (int i = 1; i < int'(DEPTH); i++) begin
            tap_d[i] = tap_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap_d;
        end
    end

    assign out_valid = tap_q[DEPTH-1];

endmodule

// File: rtl/fft_frame_loader_7.sv
// Sliding 8-sample window feeding the FFT core; emits a frame every HOP samples once primed,
// plus a valid strobe delayed to line up with the core's registered outputs.
module fft_frame_loader_7
    import fft_frame_loader_7_pkg::*;
#(
    parameter int unsigned HOP         = 8,
    parameter int unsigned FFT_LATENCY = FFT_LATENCY_DEFAULT,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                sync_clear,
    output logic [SAMPLE_W-1:0] x_0,
    output logic [SAMPLE_W-1:0] x_1,
    output logic [SAMPLE_W-1:0] x_2,
    output logic [SAMPLE_W-1:0] x_3,
    output logic [SAMPLE_W-1:0] x_4,
    output logic [SAMPLE_W-1:0] x_5,
    output logic [SAMPLE_W-1:0] x_6,
    output logic [SAMPLE_W-1:0] x_7,
    output logic                frame_valid,
    output logic                fft_valid,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                primed
);

    localparam logic [FILL_W-1:0] FillFull = FILL_W'(FFT_N);
    localparam logic [FILL_W-1:0] HopLast  = FILL_W'(HOP - 1);

    // Index 0 is the oldest sample.
    sample_t [FFT_N-1:0] win_q, win_d;
    sample_t [FFT_N-1:0] frame_q, frame_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [FILL_W-1:0]   hop_q, hop_d;
    logic                primed_q, primed_d;
    logic                frame_valid_q, frame_evt;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        win_d     = win_q;
        fill_d    = fill_q;
        hop_d     = hop_q;
        frame_evt = 1'b0;

        // A clear drops any coincident sample.
        if (sync_clear) begin
            fill_d = '0;
            hop_d  = '0;
        end else if (sample_valid) begin
            win_d = {sample_in, win_q[FFT_N-1:1]};
            if (fill_q == FillFull - 1'b1) begin
                fill_d    = FillFull;
                hop_d     = '0;
                frame_evt = 1'b1;
            end else if (fill_q == FillFull) begin
                if (hop_q == HopLast) begin
                    hop_d     = '0;
                    frame_evt = 1'b1;
                end else begin
                    hop_d = hop_q + 1'b1;
                end
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end

        primed_d = (fill_d == FillFull);
        frame_d  = frame_evt ? win_d : frame_q;
        cnt_d    = cnt_q + CNT_W'(frame_evt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q         <= '0;
            frame_q       <= '0;
            fill_q        <= '0;
            hop_q         <= '0;
            primed_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            win_q         <= win_d;
            frame_q       <= frame_d;
            fill_q        <= fill_d;
            hop_q         <= hop_d;
            primed_q      <= primed_d;
            frame_valid_q <= frame_evt;
            cnt_q         <= cnt_d;
        end
    end

    fft_frame_loader_7_valid_delay_line #(
        .DEPTH(FFT_LATENCY)
    ) u_fft_valid_dly (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (frame_valid_q),
        .out_valid(fft_valid)
    );

    assign x_0         = frame_q[0];
    assign x_1         = frame_q[1];
    assign x_2         = frame_q[2];
    assign x_3         = frame_q[3];
    assign x_4         = frame_q[4];
    assign x_5         = frame_q[5];
    assign x_6         = frame_q[6];
    assign x_7         = frame_q[7];
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = cnt_q;
    assign primed      = primed_q;

endmodule

// File: tb/tb_fft_frame_loader_7.sv
// Bench: three loaders (HOP 8/2/1, the last with a 3-bit frame counter) share one stimulus
// stream and are checked every cycle against a sample-count model.
module tb_fft_frame_loader_7;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sync_clear = 1'b0;

    logic [11:0] xo [NDUT][8];
    logic        fv_o [NDUT];
    logic        ffv_o [NDUT];
    logic        pr_o [NDUT];
    logic [15:0] fc0, fc1;
    logic [2:0]  fc2;

    int nchecks = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fft_frame_loader_7 #(.HOP(8), .FFT_LATENCY(3), .CNT_W(16)) u_d0 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .sync_clear(sync_clear),
        .x_0(xo[0][0]), .x_1(xo[0][1]), .x_2(xo[0][2]), .x_3(xo[0][3]),
        .x_4(xo[0][4]), .x_5(xo[0][5]), .x_6(xo[0][6]), .x_7(xo[0][7]),
        .frame_valid(fv_o[0]), .fft_valid(ffv_o[0]), .frame_cnt(fc0), .primed(pr_o[0])
    );

    fft_frame_loader_7 #(.HOP(2), .FFT_LATENCY(3), .CNT_W(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .sync_clear(sync_clear),
        .x_0(xo[1][0]), .x_1(xo[1][1]), .x_2(xo[1][2]), .x_3(xo[1][3]),
        .x_4(xo[1][4]), .x_5(xo[1][5]), .x_6(xo[1][6]), .x_7(xo[1][7]),
        .frame_valid(fv_o[1]), .fft_valid(ffv_o[1]), .frame_cnt(fc1), .primed(pr_o[1])
    );

    fft_frame_loader_7 #(.HOP(1), .FFT_LATENCY(3), .CNT_W(3)) u_d2 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .sync_clear(sync_clear),
        .x_0(xo[2][0]), .x_1(xo[2][1]), .x_2(xo[2][2]), .x_3(xo[2][3]),
        .x_4(xo[2][4]), .x_5(xo[2][5]), .x_6(xo[2][6]), .x_7(xo[2][7]),
        .frame_valid(fv_o[2]), .fft_valid(ffv_o[2]), .frame_cnt(fc2), .primed(pr_o[2])
    );

    function automatic int hop_of(input int k);
        return (k == 0) ? 8 : (k == 1) ? 2 : 1;
    endfunction

    function automatic int cmask(input int k);
        return (k == 2) ? 7 : 16'hFFFF;
    endfunction

    function automatic logic [31:0] get_fc(input int k);
        return (k == 0) ? 32'(fc0) : (k == 1) ? 32'(fc1) : 32'(fc2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frames fire when the count of samples accepted since reset/clear reaches 8 and
    // every HOP samples thereafter; fft_valid is frame_valid seen 3 cycles earlier.
    int       mwin [NDUT][8];
    int       mx [NDUT][8];
    int       mcnt [NDUT];
    int       mfc [NDUT];
    bit       mfv [NDUT];
    bit [31:0] mhist [NDUT];

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            mcnt[k] = 0; mfc[k] = 0; mfv[k] = 0; mhist[k] = '0;
            for (int i = 0; i < 8; i++) begin mwin[k][i] = 0; mx[k][i] = 0; end
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < NDUT; k++) begin
                if (!rst_n) begin
                    mcnt[k] = 0; mfc[k] = 0; mfv[k] = 0; mhist[k] = '0;
                    for (int i = 0; i < 8; i++) begin mwin[k][i] = 0; mx[k][i] = 0; end
                end else begin
                    mfv[k] = 0;
                    if (sync_clear) begin
                        mcnt[k] = 0;
                    end else if (sample_valid) begin
                        for (int i = 0; i < 7; i++) mwin[k][i] = mwin[k][i+1];
                        mwin[k][7] = int'(sample_in);
                        mcnt[k]++;
                        if (mcnt[k] >= 8 && (mcnt[k] - 8) % hop_of(k) == 0) begin
                            for (int i = 0; i < 8; i++) mx[k][i] = mwin[k][i];
                            mfv[k] = 1;
                            mfc[k] = (mfc[k] + 1) & cmask(k);
                        end
                    end
                    mhist[k] = {mhist[k][30:0], mfv[k]};
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                for (int i = 0; i < 8; i++)
                    check($sformatf("d%0d x_%0d", k, i), 32'(xo[k][i]), 32'(mx[k][i]));
                check($sformatf("d%0d frame_valid", k), 32'(fv_o[k]), 32'(mfv[k]));
                check($sformatf("d%0d fft_valid", k), 32'(ffv_o[k]), 32'(mhist[k][3]));
                check($sformatf("d%0d frame_cnt", k), get_fc(k), 32'(mfc[k]));
                check($sformatf("d%0d primed", k), 32'(pr_o[k]), 32'(mcnt[k] >= 8));
            end
        end
    end

    task automatic send(input int v, input bit clr = 1'b0);
        sample_in    = 12'(v);
        sample_valid = 1'b1;
        sync_clear   = clr;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sync_clear   = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        sync_clear   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Continuous 1..16: frames for HOP=8 at 8 and 16, HOP=2 at 8,10,12,..., HOP=1 every sample.
        for (int v = 1; v <= 16; v++) begin
            send(v);
            if (v == 8) begin
                check("lit d0 x_0 first frame", 32'(xo[0][0]), 32'd1);
                check("lit d0 x_3 first frame", 32'(xo[0][3]), 32'd4);
                check("lit d0 x_7 first frame", 32'(xo[0][7]), 32'd8);
                check("lit d0 frame_valid", 32'(fv_o[0]), 32'd1);
                check("lit d0 primed", 32'(pr_o[0]), 32'd1);
                check("lit d0 frame_cnt 1", 32'(fc0), 32'd1);
            end
            if (v == 11) check("lit d0 fft_valid +3", 32'(ffv_o[0]), 32'd1);
            if (v == 12) begin
                check("lit d1 x_0 third frame", 32'(xo[1][0]), 32'd5);
                check("lit d1 x_7 third frame", 32'(xo[1][7]), 32'd12);
                check("lit d1 frame_cnt 3", 32'(fc1), 32'd3);
            end
        end
        check("lit d0 frame_cnt 2", 32'(fc0), 32'd2);
        check("lit d0 x_0 second frame", 32'(xo[0][0]), 32'd9);
        check("lit d2 frame_cnt wrapped", 32'(fc2), 32'd1);

        // Clear coincides with sample 6, which is dropped.
        for (int v = 1; v <= 5; v++) send(v);
        send(6, 1'b1);
        check("lit d0 no frame at clear", 32'(fv_o[0]), 32'd0);
        check("lit d0 primed cleared", 32'(pr_o[0]), 32'd0);
        check("lit d0 x_0 held", 32'(xo[0][0]), 32'd9);
        send(7);
        send(8);
        for (int v = 101; v <= 108; v++) begin
            send(v);
            if (v == 106) begin
                check("lit d0 x_0 after clear", 32'(xo[0][0]), 32'd7);
                check("lit d0 x_1 after clear", 32'(xo[0][1]), 32'd8);
                check("lit d0 x_7 after clear", 32'(xo[0][7]), 32'd106);
                check("lit d0 frame after clear", 32'(fv_o[0]), 32'd1);
            end
        end

        // Gapped strobes: 1 on, 3 off.
        send(0, 1'b1);
        for (int v = 201; v <= 208; v++) begin
            send(v);
            if (v == 208) begin
                check("lit d0 gapped x_0", 32'(xo[0][0]), 32'd201);
                check("lit d0 gapped x_7", 32'(xo[0][7]), 32'd208);
                check("lit d0 gapped frame", 32'(fv_o[0]), 32'd1);
            end
            idle(3);
        end

        // HOP=1 streaming, then reset mid-stream with fft_valid pulses in flight.
        for (int v = 1; v <= 12; v++) send(v + 300);
        check("lit d2 streaming fft_valid", 32'(ffv_o[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("lit d2 reset frame_valid", 32'(fv_o[2]), 32'd0);
        check("lit d2 reset fft_valid", 32'(ffv_o[2]), 32'd0);
        check("lit d2 reset x_7", 32'(xo[2][7]), 32'd0);
        check("lit d2 reset primed", 32'(pr_o[2]), 32'd0);
        check("lit d0 reset frame_cnt", 32'(fc0), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
